// File: rtl/regfile_operand_master.sv
// Operand fetch/writeback initiator for the operand regfile port.
// Reads two sources, presents them to the consumer, then optionally writes back a result.
module regfile_operand_master #(
  parameter int A_WIDTH = 4,
  parameter int D_WIDTH = 32
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Req_Valid_i,
  output logic               Req_Ready_o,
  input  logic [A_WIDTH-1:0] Req_SrcA_i,
  input  logic [A_WIDTH-1:0] Req_SrcB_i,
  input  logic [A_WIDTH-1:0] Req_Dst_i,
  input  logic               Req_Wb_i,
  output logic [D_WIDTH-1:0] Op_A_o,
  output logic [D_WIDTH-1:0] Op_B_o,
  output logic               Op_Valid_o,
  input  logic               Op_Ready_i,
  input  logic [D_WIDTH-1:0] Wb_Data_i,
  input  logic               Wb_Valid_i,
  output logic               Wb_Ready_o,
  output logic [A_WIDTH-1:0] Rf_Addr_o,
  output logic               Rf_RW_o,
  output logic               Rf_En_o,
  output logic [D_WIDTH-1:0] Rf_Wdata_o,
  input  logic [D_WIDTH-1:0] Rf_Rdata_i
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_A    = 3'd1,
    RD_B    = 3'd2,
    CAP_B   = 3'd3,
    OPS     = 3'd4,
    WAIT_WB = 3'd5,
    WR      = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [A_WIDTH-1:0] src_a_q, src_b_q, dst_q;
  logic               wb_q;
  logic               req_ready_q, op_valid_q, wb_ready_q;
  logic               rf_en_q, rf_rw_q;
  logic [A_WIDTH-1:0] rf_addr_q;
  logic [D_WIDTH-1:0] rf_wdata_q, op_a_q, op_b_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (Req_Valid_i && req_ready_q) state_d = RD_A;
      RD_A:    state_d = RD_B;
      RD_B:    state_d = CAP_B;
      CAP_B:   state_d = OPS;
      OPS:     if (Op_Ready_i) state_d = wb_q ? WAIT_WB : IDLE;
      WAIT_WB: if (Wb_Valid_i) state_d = WR;
      WR:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      src_a_q     <= '0;
      src_b_q     <= '0;
      dst_q       <= '0;
      wb_q        <= 1'b0;
      req_ready_q <= 1'b0;
      op_valid_q  <= 1'b0;
      wb_ready_q  <= 1'b0;
      rf_en_q     <= 1'b0;
      rf_rw_q     <= 1'b0;
      rf_addr_q   <= '0;
      rf_wdata_q  <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == RD_A) begin
        src_a_q <= Req_SrcA_i;
        src_b_q <= Req_SrcB_i;
        dst_q   <= Req_Dst_i;
        wb_q    <= Req_Wb_i;
      end
      if (state_q == RD_B)  op_a_q <= Rf_Rdata_i;
      if (state_q == CAP_B) op_b_q <= Rf_Rdata_i;

      req_ready_q <= (state_d == IDLE);
      op_valid_q  <= (state_d == OPS);
      wb_ready_q  <= (state_d == WAIT_WB);
      rf_en_q     <= (state_d == RD_A) || (state_d == RD_B) || (state_d == WR);
      rf_rw_q     <= (state_d == WR);

      unique case (state_d)
        RD_A:    rf_addr_q <= (state_q == IDLE) ? Req_SrcA_i : src_a_q;
        RD_B:    rf_addr_q <= src_b_q;
        WR:      rf_addr_q <= dst_q;
        default: rf_addr_q <= '0;
      endcase
      // WR is only reached through the writeback handshake, so Wb_Data_i is the result here.
      rf_wdata_q <= (state_d == WR) ? Wb_Data_i : '0;
    end
  end

  assign Req_Ready_o = req_ready_q;
  assign Op_Valid_o  = op_valid_q;
  assign Op_A_o      = op_a_q;
  assign Op_B_o      = op_b_q;
  assign Wb_Ready_o  = wb_ready_q;
  assign Rf_En_o     = rf_en_q;
  assign Rf_RW_o     = rf_rw_q;
  assign Rf_Addr_o   = rf_addr_q;
  assign Rf_Wdata_o  = rf_wdata_q;

endmodule

// File: tb/tb_regfile_operand_master.sv
// Directed bench for regfile_operand_master with a behavioural registered-read regfile.
module tb_regfile_operand_master;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Req_Valid = 1'b0;
  logic        Req_Ready;
  logic [3:0]  Req_SrcA = '0, Req_SrcB = '0, Req_Dst = '0;
  logic        Req_Wb = 1'b0;
  logic [31:0] Op_A, Op_B;
  logic        Op_Valid;
  logic        Op_Ready = 1'b0;
  logic [31:0] Wb_Data = '0;
  logic        Wb_Valid = 1'b0;
  logic        Wb_Ready;
  logic [3:0]  Rf_Addr;
  logic        Rf_RW, Rf_En;
  logic [31:0] Rf_Wdata;
  logic [31:0] Rf_Rdata = '0;

  logic [31:0] mem [16];
  int          rd_cnt = 0, wr_cnt = 0;
  int          n_checks = 0, n_fail = 0;

  always #5 Clk = ~Clk;

  regfile_operand_master #(.A_WIDTH(4), .D_WIDTH(32)) dut (
    .Clk(Clk), .Rst(Rst),
    .Req_Valid_i(Req_Valid), .Req_Ready_o(Req_Ready),
    .Req_SrcA_i(Req_SrcA), .Req_SrcB_i(Req_SrcB), .Req_Dst_i(Req_Dst), .Req_Wb_i(Req_Wb),
    .Op_A_o(Op_A), .Op_B_o(Op_B), .Op_Valid_o(Op_Valid), .Op_Ready_i(Op_Ready),
    .Wb_Data_i(Wb_Data), .Wb_Valid_i(Wb_Valid), .Wb_Ready_o(Wb_Ready),
    .Rf_Addr_o(Rf_Addr), .Rf_RW_o(Rf_RW), .Rf_En_o(Rf_En),
    .Rf_Wdata_o(Rf_Wdata), .Rf_Rdata_i(Rf_Rdata)
  );

  // Regfile model: read data registered, valid one cycle after the strobe, zero otherwise.
  always @(posedge Clk) begin
    Rf_Rdata <= (Rf_En && !Rf_RW) ? mem[Rf_Addr] : 32'h0;
    if (Rf_En && Rf_RW) mem[Rf_Addr] <= Rf_Wdata;
    if (Rf_En && !Rf_RW) rd_cnt <= rd_cnt + 1;
    if (Rf_En && Rf_RW) wr_cnt <= wr_cnt + 1;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Presents a request in IDLE; returns with the accept edge just passed.
  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d, input logic wb);
    int n = 0;
    while (!Req_Ready && n < 20) begin tick(); n++; end
    n_checks++;
    if (Req_Ready !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_ready: Req_Ready=%b required 1", Req_Ready);
    end
    Req_Valid = 1'b1; Req_SrcA = a; Req_SrcB = b; Req_Dst = d; Req_Wb = wb;
    tick();
    Req_Valid = 1'b0; Req_SrcA = '0; Req_SrcB = '0; Req_Dst = '0; Req_Wb = 1'b0;
  endtask

  // Returns the number of edges after the accept edge until Op_Valid is seen (capped at 20).
  task automatic wait_ops(output int cyc);
    cyc = 0;
    while (!Op_Valid && cyc < 20) begin tick(); cyc++; end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    tick(); tick();
    n_checks++;
    if ({Req_Ready, Op_Valid, Wb_Ready, Rf_En, Rf_RW} !== 5'b0 || Rf_Addr !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_ctrl: rdy=%b opv=%b wbr=%b en=%b rw=%b addr=%h required all 0",
               Req_Ready, Op_Valid, Wb_Ready, Rf_En, Rf_RW, Rf_Addr);
    end
    n_checks++;
    if (Op_A !== 32'h0 || Op_B !== 32'h0 || Rf_Wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: Op_A=%h Op_B=%h Wdata=%h required 0", Op_A, Op_B, Rf_Wdata);
    end
    Rst = 1'b0;
    tick();
    n_checks++;
    if (Req_Ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: Req_Ready=%b required 1", Req_Ready);
    end
  endtask

  task automatic test_read_path();
    int rd0, cyc;
    rd0 = rd_cnt;
    issue(4'd3, 4'd7, 4'd0, 1'b0);
    n_checks++;
    if (Req_Ready !== 1'b0 || Rf_En !== 1'b1 || Rf_RW !== 1'b0 || Rf_Addr !== 4'd3) begin
      n_fail++;
      $display("FAIL rd_a_strobe: rdy=%b en=%b rw=%b addr=%0d required 0 1 0 3", Req_Ready, Rf_En, Rf_RW, Rf_Addr);
    end
    wait_ops(cyc);
    n_checks++;
    if (cyc !== 3) begin
      n_fail++;
      $display("FAIL rd_latency: Op_Valid after %0d edges required 3", cyc);
    end
    n_checks++;
    if (Op_A !== 32'hDEADBEEF || Op_B !== 32'h12345678) begin
      n_fail++;
      $display("FAIL rd_data: Op_A=%h Op_B=%h required deadbeef 12345678", Op_A, Op_B);
    end
    Op_Ready = 1'b1;
    tick();
    Op_Ready = 1'b0;
    n_checks++;
    if (Op_Valid !== 1'b0 || Req_Ready !== 1'b1 || rd_cnt - rd0 !== 2) begin
      n_fail++;
      $display("FAIL rd_done: opv=%b rdy=%b reads=%0d required 0 1 2", Op_Valid, Req_Ready, rd_cnt - rd0);
    end
  endtask

  task automatic test_backpressure();
    int cyc, bad;
    bad = 0;
    issue(4'd3, 4'd7, 4'd0, 1'b0);
    wait_ops(cyc);
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (Op_Valid !== 1'b1 || Op_A !== 32'hDEADBEEF || Op_B !== 32'h12345678 ||
          Req_Ready !== 1'b0 || Rf_En !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure[%0d]: opv=%b A=%h B=%h rdy=%b en=%b required 1 deadbeef 12345678 0 0",
                 i, Op_Valid, Op_A, Op_B, Req_Ready, Rf_En);
      end
    end
    Op_Ready = 1'b1;
    tick();
    Op_Ready = 1'b0;
    n_checks++;
    if (Op_Valid !== 1'b0 || Op_A !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL bp_release: opv=%b A=%h required 0 deadbeef", Op_Valid, Op_A);
    end
  endtask

  task automatic test_writeback();
    int wr0, cyc;
    wr0 = wr_cnt;
    issue(4'd1, 4'd2, 4'd5, 1'b1);
    wait_ops(cyc);
    n_checks++;
    if (Op_A !== 32'h11111111 || Op_B !== 32'h22222222) begin
      n_fail++;
      $display("FAIL wb_ops: Op_A=%h Op_B=%h required 11111111 22222222", Op_A, Op_B);
    end
    Op_Ready = 1'b1;
    tick();
    Op_Ready = 1'b0;
    n_checks++;
    if (Wb_Ready !== 1'b1 || Req_Ready !== 1'b0 || Rf_En !== 1'b0) begin
      n_fail++;
      $display("FAIL wb_wait: wbr=%b rdy=%b en=%b required 1 0 0", Wb_Ready, Req_Ready, Rf_En);
    end
    Wb_Valid = 1'b1; Wb_Data = 32'hA5A5A5A5;
    tick();
    Wb_Valid = 1'b0; Wb_Data = 32'h0;
    n_checks++;
    if (Rf_En !== 1'b1 || Rf_RW !== 1'b1 || Rf_Addr !== 4'd5 || Rf_Wdata !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL wb_strobe: en=%b rw=%b addr=%0d data=%h required 1 1 5 a5a5a5a5", Rf_En, Rf_RW, Rf_Addr, Rf_Wdata);
    end
    tick();
    n_checks++;
    if (wr_cnt - wr0 !== 1 || Rf_En !== 1'b0 || Req_Ready !== 1'b1 || Rf_Wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL wb_done: writes=%0d en=%b rdy=%b wdata=%h required 1 0 1 0", wr_cnt - wr0, Rf_En, Req_Ready, Rf_Wdata);
    end
    issue(4'd5, 4'd1, 4'd0, 1'b0);
    wait_ops(cyc);
    n_checks++;
    if (Op_A !== 32'hA5A5A5A5 || Op_B !== 32'h11111111) begin
      n_fail++;
      $display("FAIL wb_readback: Op_A=%h Op_B=%h required a5a5a5a5 11111111", Op_A, Op_B);
    end
    Op_Ready = 1'b1;
    tick();
    Op_Ready = 1'b0;
  endtask

  task automatic test_same_source();
    int rd0, cyc;
    rd0 = rd_cnt;
    issue(4'd9, 4'd9, 4'd0, 1'b0);
    wait_ops(cyc);
    n_checks++;
    if (Op_A !== 32'h55 || Op_B !== 32'h55 || rd_cnt - rd0 !== 2) begin
      n_fail++;
      $display("FAIL same_src: Op_A=%h Op_B=%h reads=%0d required 55 55 2", Op_A, Op_B, rd_cnt - rd0);
    end
    Op_Ready = 1'b1;
    tick();
    Op_Ready = 1'b0;
  endtask

  task automatic test_rst_mid_op();
    int wr0, cyc;
    issue(4'd1, 4'd2, 4'd6, 1'b1);
    wait_ops(cyc);
    Op_Ready = 1'b1;
    tick();
    Op_Ready = 1'b0;
    n_checks++;
    if (Wb_Ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre: Wb_Ready=%b required 1", Wb_Ready);
    end
    wr0 = wr_cnt;
    Wb_Valid = 1'b1; Wb_Data = 32'hCAFEF00D; Rst = 1'b1;
    tick();
    n_checks++;
    if (Rf_En !== 1'b0 || Rf_RW !== 1'b0 || Wb_Ready !== 1'b0 || Op_Valid !== 1'b0 || Req_Ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: en=%b rw=%b wbr=%b opv=%b rdy=%b required all 0", Rf_En, Rf_RW, Wb_Ready, Op_Valid, Req_Ready);
    end
    Rst = 1'b0;
    tick();
    Wb_Valid = 1'b0; Wb_Data = 32'h0;
    tick();
    n_checks++;
    if (Req_Ready !== 1'b1 || Wb_Ready !== 1'b0 || wr_cnt - wr0 !== 0 || mem[6] !== 32'h66666666) begin
      n_fail++;
      $display("FAIL rst_after: rdy=%b wbr=%b writes=%0d R6=%h required 1 0 0 66666666",
               Req_Ready, Wb_Ready, wr_cnt - wr0, mem[6]);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = {8{i[3:0]}};
    mem[3] = 32'hDEADBEEF;
    mem[7] = 32'h12345678;
    mem[9] = 32'h00000055;
    test_reset();
    test_read_path();
    test_backpressure();
    test_writeback();
    test_same_source();
    test_rst_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
